// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state encoding and default parameters for fifo_rd_arbiter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching upward from last+1
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_last,
   output logic               o_valid,
   output logic [IW-1:0]      o_idx
);

   logic [IW-1:0] w_cand;

   // scan farthest candidate first so the nearest requester after last wins
   always_comb begin
      o_valid = |i_req;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = IW'((int'(i_last) + k) % NUM_REQ);
         if (i_req[w_cand]) o_idx = w_cand;
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin arbitration of FIFO read access among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to allow up to BURST_LEN back-to-back reads per grant;
// otherwise each grant carries exactly one read.
module fifo_rd_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  r_en,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [NUM_REQ-1:0]    dout_valid
);

`ifdef FIFO_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam int QUOTA = BURST ? BURST_LEN : 1;
   localparam int IW    = $clog2(NUM_REQ);
   localparam int CW    = $clog2(QUOTA + 1);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_t              r_state;
   logic [IW-1:0]       r_owner;
   logic [IW-1:0]       r_last;
   logic [CW-1:0]       r_cnt;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  r_dv;
   logic                w_valid;
   logic [IW-1:0]       w_idx;
   logic                w_exit;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req   (req),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   // a read goes out only while the owner still asks and data is present
   assign r_en       = (r_state == SERVE) && req[r_owner] && !empty;
   assign w_exit     = !req[r_owner] || empty || (r_en && r_cnt == CW'(QUOTA - 1));
   assign gnt        = r_gnt;
   assign dout       = rdata;
   assign dout_valid = r_dv;

   // arbitration FSM with registered grant, owner, last-served and read count
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= IW'(NUM_REQ - 1);
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_dv    <= '0;
      end else begin
         r_dv <= r_en ? r_gnt : '0;
         if (r_state == IDLE) begin
            r_cnt <= '0;
            if (w_valid && !empty) begin
               r_state <= SERVE;
               r_owner <= w_idx;
               r_gnt   <= ONE << w_idx;
            end
         end else begin
            if (r_en) r_cnt <= r_cnt + 1'b1;
            if (w_exit) begin
               r_state <= IDLE;
               r_gnt   <= '0;
               r_last  <= r_owner;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed self-checking bench for fifo_rd_arbiter (NUM_REQ=4, DATA_WIDTH=8)
module tb_fifo_rd_arbiter;

   logic       rclk = 1'b0;
   logic       rrst_n = 1'b0;
   logic [3:0] req = '0;
   logic       empty = 1'b1;
   logic [7:0] rdata = '0;
   logic       r_en;
   logic [3:0] gnt;
   logic [7:0] dout;
   logic [3:0] dout_valid;
   int         tests = 0;
   int         fails = 0;

   fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .req        (req),
      .empty      (empty),
      .rdata      (rdata),
      .r_en       (r_en),
      .gnt        (gnt),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   always #5 rclk = ~rclk;

   task automatic step;
      @(posedge rclk);
      #1;
   endtask

   task automatic apply_reset;
      @(posedge rclk);
      #1 rrst_n = 1'b0;
      req   = '0;
      empty = 1'b1;
      #3 rrst_n = 1'b1;
   endtask

   task automatic test_reset;
      req   = 4'b1111;
      empty = 1'b0;
      rrst_n = 1'b0;
      step();
      step();
      tests++;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      tests++;
      if (r_en !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b want 0", r_en); end
      tests++;
      if (dout_valid !== 4'b0000) begin fails++; $display("FAIL reset_dv: got %b want 0000", dout_valid); end
      req   = '0;
      empty = 1'b1;
      #2 rrst_n = 1'b1;
   endtask

   task automatic test_single;
      apply_reset();
      req   = 4'b0001;
      empty = 1'b0;
      rdata = 8'hA5;
      step();
      tests++;
      if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b want 0001", gnt); end
      tests++;
      if (r_en !== 1'b1) begin fails++; $display("FAIL single_ren: got %b want 1", r_en); end
      tests++;
      if (dout_valid !== 4'b0000) begin fails++; $display("FAIL single_dv_early: got %b want 0000", dout_valid); end
      step();
      tests++;
      if (dout_valid !== 4'b0001) begin fails++; $display("FAIL single_dv: got %b want 0001", dout_valid); end
      tests++;
      if (gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_drop: got %b want 0000", gnt); end
      tests++;
      if (dout !== 8'hA5) begin fails++; $display("FAIL single_dout: got %h want a5", dout); end
      req = '0;
      step();
      tests++;
      if (dout_valid !== 4'b0000) begin fails++; $display("FAIL single_dv_clear: got %b want 0000", dout_valid); end
   endtask

   task automatic test_rotate;
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset();
      req   = 4'b1111;
      empty = 1'b0;
      for (int g = 0; g < 5; g++) begin
         step();
         tests++;
         if (gnt !== exp_g[g] || r_en !== 1'b1) begin
            fails++;
            $display("FAIL rotate_gnt[%0d]: got gnt=%b r_en=%b want gnt=%b r_en=1", g, gnt, r_en, exp_g[g]);
         end
         step();
         tests++;
         if (gnt !== 4'b0000 || dout_valid !== exp_g[g]) begin
            fails++;
            $display("FAIL rotate_gap[%0d]: got gnt=%b dv=%b want gnt=0000 dv=%b", g, gnt, dout_valid, exp_g[g]);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_empty;
      apply_reset();
      req   = 4'b0010;
      empty = 1'b0;
      step();
      tests++;
      if (gnt !== 4'b0010) begin fails++; $display("FAIL empty_gnt: got %b want 0010", gnt); end
      empty = 1'b1;
      #1;
      tests++;
      if (r_en !== 1'b0) begin fails++; $display("FAIL empty_ren: got %b want 0", r_en); end
      step();
      tests++;
      if (gnt !== 4'b0000 || dout_valid !== 4'b0000) begin
         fails++;
         $display("FAIL empty_exit: got gnt=%b dv=%b want 0000/0000", gnt, dout_valid);
      end
      step();
      step();
      tests++;
      if (gnt !== 4'b0000 || r_en !== 1'b0) begin
         fails++;
         $display("FAIL empty_hold: got gnt=%b r_en=%b want 0000/0", gnt, r_en);
      end
      empty = 1'b0;
      step();
      tests++;
      if (gnt !== 4'b0010 || r_en !== 1'b1) begin
         fails++;
         $display("FAIL empty_regrant: got gnt=%b r_en=%b want 0010/1", gnt, r_en);
      end
      req = '0;
      step();
   endtask

   task automatic test_drop;
      apply_reset();
      req   = 4'b0101;
      empty = 1'b0;
      step();
      tests++;
      if (gnt !== 4'b0001) begin fails++; $display("FAIL drop_gnt: got %b want 0001", gnt); end
      req = 4'b0100;
      #1;
      tests++;
      if (r_en !== 1'b0) begin fails++; $display("FAIL drop_ren: got %b want 0", r_en); end
      step();
      tests++;
      if (gnt !== 4'b0000 || dout_valid !== 4'b0000) begin
         fails++;
         $display("FAIL drop_exit: got gnt=%b dv=%b want 0000/0000", gnt, dout_valid);
      end
      req = 4'b0101;
      step();
      tests++;
      if (gnt !== 4'b0100) begin fails++; $display("FAIL drop_next: got %b want 0100", gnt); end
      req = '0;
      step();
   endtask

   task automatic test_reset_mid;
      apply_reset();
      req   = 4'b0100;
      empty = 1'b0;
      step();
      tests++;
      if (gnt !== 4'b0100 || r_en !== 1'b1) begin
         fails++;
         $display("FAIL rmid_pre: got gnt=%b r_en=%b want 0100/1", gnt, r_en);
      end
      #1 rrst_n = 1'b0;
      #1;
      tests++;
      if (r_en !== 1'b0 || gnt !== 4'b0000 || dout_valid !== 4'b0000) begin
         fails++;
         $display("FAIL rmid_async: got r_en=%b gnt=%b dv=%b want 0/0000/0000", r_en, gnt, dout_valid);
      end
      req = 4'b0101;
      #1 rrst_n = 1'b1;
      step();
      tests++;
      if (gnt !== 4'b0001 || dout_valid !== 4'b0000) begin
         fails++;
         $display("FAIL rmid_post: got gnt=%b dv=%b want 0001/0000", gnt, dout_valid);
      end
      req = '0;
      step();
   endtask

`ifdef FIFO_ARB_BURST_EN
   task automatic test_burst;
      apply_reset();
      req   = 4'b0100;
      empty = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         tests++;
         if (gnt !== 4'b0100 || r_en !== 1'b1 || dout_valid !== (c == 0 ? 4'b0000 : 4'b0100)) begin
            fails++;
            $display("FAIL burst_rd[%0d]: got gnt=%b r_en=%b dv=%b", c, gnt, r_en, dout_valid);
         end
      end
      step();
      tests++;
      if (gnt !== 4'b0000 || r_en !== 1'b0 || dout_valid !== 4'b0100) begin
         fails++;
         $display("FAIL burst_idle: got gnt=%b r_en=%b dv=%b want 0000/0/0100", gnt, r_en, dout_valid);
      end
      step();
      tests++;
      if (gnt !== 4'b0100) begin fails++; $display("FAIL burst_regrant: got %b want 0100", gnt); end
      req = '0;
      step();
   endtask
`else
   task automatic test_lone;
      apply_reset();
      req   = 4'b0100;
      empty = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         tests++;
         if (gnt !== 4'b0100 || r_en !== 1'b1) begin
            fails++;
            $display("FAIL lone_gnt[%0d]: got gnt=%b r_en=%b want 0100/1", c, gnt, r_en);
         end
         step();
         tests++;
         if (gnt !== 4'b0000 || r_en !== 1'b0 || dout_valid !== 4'b0100) begin
            fails++;
            $display("FAIL lone_gap[%0d]: got gnt=%b r_en=%b dv=%b want 0000/0/0100", c, gnt, r_en, dout_valid);
         end
      end
      req = '0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_empty();
      test_drop();
      test_reset_mid();
`ifdef FIFO_ARB_BURST_EN
      test_burst();
`else
      test_lone();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
